seq_detector_prog: RTL

Programmable serial bit-pattern detector, the parametrised successor to the fixed 10110 Moore detector. It samples a qualified serial input and compares the most recent bits against a runtime-loaded pattern of 1..MAX_LEN bits. Overlap or non-overlap matching is selectable at runtime. Each match produces a registered one-cycle Moore pulse and increments a saturating match counter, for use by protocol front-ends needing framing/sync-word detection.

---
 rtl/seq_detector_prog.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial bit-pattern detector.
// Compares the most recent qualified samples of x against a runtime-loaded,
// right-aligned pattern of 1..MAX_LEN bits. z is a registered one-cycle match
// pulse; match_cnt is a saturating count of matches.
//
// Sequencing view (fill counter holds the progress):
//   fill          | meaning
//   0             | no history (after reset, cfg load, or a non-overlap hit)
//   1..len_r-1    | collecting bits, a hit is not yet possible
//   len_r..MAX    | window full, every sample is compared against the pattern
module seq_detector_prog #(
   parameter int                 MAX_LEN = 8,
   parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
   parameter int                 CNT_W   = 16,
   parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0001_0110,
   parameter int                 RST_LEN = 5,
   parameter logic               RST_OVL = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               x_valid,
   input  logic               x,
   input  logic               cnt_clr,
   output logic               z,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] RST_LEN_L =
      (RST_LEN > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(RST_LEN);

   logic [MAX_LEN-1:0] r_pat;
   logic [LEN_W-1:0]   r_len;
   logic               r_ovl;
   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic               r_z;
   logic [CNT_W-1:0]   r_cnt;

   logic [MAX_LEN-1:0] w_pat_n;
   logic [LEN_W-1:0]   w_len_n;
   logic               w_ovl_n;
   logic [MAX_LEN-1:0] w_hist_n;
   logic [LEN_W-1:0]   w_fill_n;
   logic               w_z_n;
   logic [CNT_W-1:0]   w_cnt_n;

   logic [MAX_LEN-1:0] w_shift;
   logic [LEN_W-1:0]   w_fill_inc;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_cmp;
   logic               w_hit;

   assign w_shift    = {r_hist[MAX_LEN-2:0], x};
   assign w_fill_inc = (r_fill == MAX_LEN_L) ? r_fill : r_fill + 1'b1;
   assign w_cmp      = (r_len != '0) && (w_fill_inc >= r_len) &&
                       ((w_shift & w_mask) == (r_pat & w_mask));
   // a sample coinciding with a config load is discarded
   assign w_hit      = x_valid && !cfg_load && w_cmp;

   // compare window: the low r_len bits of the history
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (LEN_W'(i) < r_len);
      end
   end

   // next-state for config, history, fill, pulse and counter
   always_comb begin
      w_pat_n  = r_pat;
      w_len_n  = r_len;
      w_ovl_n  = r_ovl;
      w_hist_n = r_hist;
      w_fill_n = r_fill;
      w_z_n    = 1'b0;
      w_cnt_n  = r_cnt;

      if (cfg_load) begin
         w_pat_n  = cfg_pat;
         w_len_n  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
         w_ovl_n  = cfg_overlap;
         w_hist_n = '0;
         w_fill_n = '0;
      end else if (x_valid) begin
         if (w_hit && !r_ovl) begin
            w_hist_n = '0;
            w_fill_n = '0;
         end else begin
            w_hist_n = w_shift;
            w_fill_n = w_fill_inc;
         end
         w_z_n = w_hit;
      end

      // clear beats a same-cycle increment; z still pulses
      if (cnt_clr) begin
         w_cnt_n = '0;
      end else if (w_hit && (r_cnt != '1)) begin
         w_cnt_n = r_cnt + 1'b1;
      end
   end

   // state registers, async active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat  <= RST_PAT;
         r_len  <= RST_LEN_L;
         r_ovl  <= RST_OVL;
         r_hist <= '0;
         r_fill <= '0;
         r_z    <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_pat  <= w_pat_n;
         r_len  <= w_len_n;
         r_ovl  <= w_ovl_n;
         r_hist <= w_hist_n;
         r_fill <= w_fill_n;
         r_z    <= w_z_n;
         r_cnt  <= w_cnt_n;
      end
   end

   assign z         = r_z;
   assign match_cnt = r_cnt;

endmodule
